vga_timing_gen: RTL

//   Raster timing generator for the 640x480@60 VGA path; sits directly upstream of every sprite/palette draw stage.

---
 rtl/vga_timing_pkg.sv | 25 ++
 rtl/vga_axis_counter.sv | 53 +++++
 rtl/vga_timing_gen.sv | 97 +++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster timing constants and coordinate type for the VGA timing generator.
package vga_timing_pkg;

   localparam int CNT_W       = 10;
   localparam int FRAME_CNT_W = 16;

   localparam int H_VISIBLE = 640;
   localparam int H_FRONT   = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BACK    = 48;
   localparam int V_VISIBLE = 480;
   localparam int V_FRONT   = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BACK    = 33;

   localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

   typedef logic [CNT_W-1:0] coord_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter plus visible/sync decodes of the value it moves to next.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int W       = CNT_W,
   parameter int VISIBLE = H_VISIBLE,
   parameter int FRONT   = H_FRONT,
   parameter int SYNC    = H_SYNC,
   parameter int BACK    = H_BACK,
   parameter int RST_VAL = H_TOTAL - 1
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         inc_i,
   output logic [W-1:0] count_o,
   output logic [W-1:0] next_o,
   output logic         wrap_o,
   output logic         visible_next_o,
   output logic         sync_n_next_o
);

   localparam int TOTAL = VISIBLE + FRONT + SYNC + BACK;
   localparam logic [W-1:0] LAST_C   = W'(TOTAL - 1);
   localparam logic [W-1:0] VIS_C    = W'(VISIBLE);
   localparam logic [W-1:0] SYNC_S_C = W'(VISIBLE + FRONT);
   localparam logic [W-1:0] SYNC_E_C = W'(VISIBLE + FRONT + SYNC);
   localparam logic [W-1:0] RST_C    = W'(RST_VAL);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      wrap_o  = inc_i && (count_q == LAST_C);
      count_d = count_q;
      if (inc_i) begin
         count_d = wrap_o ? '0 : count_q + W'(1);
      end
   end

   // Decodes look at the next value so the registered flags line up with the registered count.
   assign visible_next_o = (count_d < VIS_C);
   assign sync_n_next_o  = !((count_d >= SYNC_S_C) && (count_d < SYNC_E_C));
   assign next_o         = count_d;
   assign count_o        = count_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= RST_C;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: registered DrawX/DrawY, blank, hs/vs and frame_start.
// Define VGA_FRAME_CNT_EN to add the 16-bit frame_count output.
module vga_timing_gen #(
   parameter int CNT_W     = vga_timing_pkg::CNT_W,
   parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
   parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
   parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
   parameter int H_BACK    = vga_timing_pkg::H_BACK,
   parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
   parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
   parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
   parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
   input  logic             vga_clk,
   input  logic             reset,
   output logic [CNT_W-1:0] DrawX,
   output logic [CNT_W-1:0] DrawY,
   output logic             blank,
   output logic             hs,
   output logic             vs,
   output logic             frame_start
`ifdef VGA_FRAME_CNT_EN
   ,
   output logic [vga_timing_pkg::FRAME_CNT_W-1:0] frame_count
`endif
);

   import vga_timing_pkg::*;

   localparam int H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   logic [CNT_W-1:0] h_next, v_next;
   logic             h_wrap, v_wrap;
   logic             h_vis_next, v_vis_next, h_sync_n_next, v_sync_n_next;
   logic             blank_q, hs_q, vs_q, fs_q, fs_d;

   vga_axis_counter #(
      .W(CNT_W), .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
      .RST_VAL(H_TOT - 1)
   ) u_h (
      .clk_i(vga_clk), .rst_i(reset), .inc_i(1'b1),
      .count_o(DrawX), .next_o(h_next), .wrap_o(h_wrap),
      .visible_next_o(h_vis_next), .sync_n_next_o(h_sync_n_next)
   );

   vga_axis_counter #(
      .W(CNT_W), .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
      .RST_VAL(V_TOT - 1)
   ) u_v (
      .clk_i(vga_clk), .rst_i(reset), .inc_i(h_wrap),
      .count_o(DrawY), .next_o(v_next), .wrap_o(v_wrap),
      .visible_next_o(v_vis_next), .sync_n_next_o(v_sync_n_next)
   );

   assign fs_d = (h_next == '0) && (v_next == '0);

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         blank_q <= 1'b0;
         hs_q    <= 1'b1;
         vs_q    <= 1'b1;
         fs_q    <= 1'b0;
      end else begin
         blank_q <= h_vis_next && v_vis_next;
         hs_q    <= h_sync_n_next;
         vs_q    <= v_sync_n_next;
         fs_q    <= fs_d;
      end
   end

   assign blank       = blank_q;
   assign hs          = hs_q;
   assign vs          = vs_q;
   assign frame_start = fs_q;

`ifdef VGA_FRAME_CNT_EN
   logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;

   // Starts at all-ones so the first frame after reset reads zero.
   assign frame_count_d = fs_d ? frame_count_q + FRAME_CNT_W'(1) : frame_count_q;

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         frame_count_q <= '1;
      end else begin
         frame_count_q <= frame_count_d;
      end
   end

   assign frame_count = frame_count_q;
`endif

   logic unused_wrap;
   assign unused_wrap = v_wrap;

endmodule
